// File: rtl/sr_flag_pkg.sv
// Shared definitions for the set/reset flag arbiter.
// Holds the requester op encoding and the FSM state encoding.
package sr_flag_pkg;

  // Requester op encoding (op[2i+1:2i])
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  // Arbiter FSM states
  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t ACK  = 1'b1;

endpackage : sr_flag_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req_i  per-requester request vector
//   ptr_i  requester with highest priority this round
//   gnt_o  one-hot grant (zero when no request)
//   win_o  encoded winner (zero when no request)
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PTRW = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PTRW-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PTRW-1:0] win_o
);

  // Walk the requesters starting at the pointer; first active one wins.
  always_comb begin
    logic            found;
    logic [PTRW-1:0] cand;
    gnt_o = '0;
    win_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = PTRW'((32'(ptr_i) + k) % NREQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        win_o       = cand;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter serialising set/clear requests onto a shared flag bank.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   req       per-requester request, held until ack
//   op        2-bit op per requester (nop/set/clear/illegal)
//   idx       flag index per requester
//   ack       one-cycle completion pulse to the granted requester
//   q         flag bank contents
//   err       sticky error (illegal op or out-of-range index)
//   busy      high while an op is being applied
module sr_flag_arbiter
  import sr_flag_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NFLAG = 8,
  parameter int unsigned IDXW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [IDXW*NREQ-1:0] idx,
  output logic [NREQ-1:0]      ack,
  output logic [NFLAG-1:0]     q,
  output logic                 err,
  output logic                 busy
);

  localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state_q, state_d;
  logic [PTRW-1:0]  rr_q,    rr_d;
  logic [PTRW-1:0]  win_q,   win_d;
  logic [1:0]       op_q,    op_d;
  logic [IDXW-1:0]  idx_q,   idx_d;
  logic [NFLAG-1:0] q_q,     q_d;
  logic [NREQ-1:0]  ack_q,   ack_d;
  logic             err_q,   err_d;
  logic             busy_q,  busy_d;

  logic [NREQ-1:0]  gnt_c;
  logic [PTRW-1:0]  win_c;
  logic [1:0]       op_arr_c  [NREQ];
  logic [IDXW-1:0]  idx_arr_c [NREQ];

  rr_arbiter #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_rr_arbiter (
    .req_i (req),
    .ptr_i (rr_q),
    .gnt_o (gnt_c),
    .win_o (win_c)
  );

  // Unpack the flat per-requester op/idx buses.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      op_arr_c[i]  = op[2*i +: 2];
      idx_arr_c[i] = idx[IDXW*i +: IDXW];
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    op_d    = op_q;
    idx_d   = idx_q;
    q_d     = q_q;
    ack_d   = '0;
    err_d   = err_q;
    busy_d  = busy_q;

    case (state_q)
      IDLE: begin
        if (|gnt_c) begin
          win_d   = win_c;
          op_d    = op_arr_c[win_c];
          idx_d   = idx_arr_c[win_c];
          busy_d  = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        // Only one op per update, so a flag can never see set and clear together.
        case (op_q)
          OP_SET: begin
            if (32'(idx_q) < NFLAG) q_d[idx_q] = 1'b1;
            else                    err_d      = 1'b1;
          end
          OP_CLR: begin
            if (32'(idx_q) < NFLAG) q_d[idx_q] = 1'b0;
            else                    err_d      = 1'b1;
          end
          OP_ILL:  err_d = 1'b1;
          default: ;
        endcase
        ack_d[win_q] = 1'b1;
        rr_d    = (32'(win_q) == NREQ - 1) ? '0 : win_q + PTRW'(1);
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any pending op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      win_q   <= '0;
      op_q    <= OP_NOP;
      idx_q   <= '0;
      q_q     <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      q_q     <= q_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign ack  = ack_q;
  assign q    = q_q;
  assign err  = err_q;
  assign busy = busy_q;

endmodule : sr_flag_arbiter
